// File: rtl/dca_matrix_load_sequencer.sv
// dca_matrix_load_sequencer
// Turns one matrix-load instruction into a series of per-row memory read
// requests for the row-unpack stage. Each request carries the row byte address,
// the row size in bytes and {last_row, row_idx}. Rows in flight (issued but not
// yet answered by rsp_fire) are capped at MAX_OUTSTANDING. done pulses once the
// last row has been issued and every outstanding response has come back.
//
// Ports
//   clk, rstnn                      clock, async active-low reset
//   inst_valid/inst_ready, inst_*   instruction handshake and fields
//   req_valid/req_ready, req_*      row request handshake, address, size, tag
//   rsp_fire                        one row consumed by the unpack stage
//   cfg_elem_log2, cfg_is_signed    element format, held from instruction accept
//   busy, done, err_underflow       status
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for an instruction; inst_ready high
// ISSUE | presenting row requests, throttled by the outstanding count
// DRAIN | all rows issued; waiting for outstanding responses to return
module dca_matrix_load_sequencer #(
    parameter int BW_ADDR         = 32,
    parameter int BW_STRIDE_LS3   = 16,
    parameter int BW_NUM_ROW_M1   = 8,
    parameter int BW_NUM_COL_M1   = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                     clk,
    input  logic                     rstnn,
    input  logic                     inst_valid,
    output logic                     inst_ready,
    input  logic [BW_ADDR-1:0]       inst_addr,
    input  logic [BW_STRIDE_LS3-1:0] inst_stride_ls3,
    input  logic [BW_NUM_ROW_M1-1:0] inst_num_row_m1,
    input  logic [BW_NUM_COL_M1-1:0] inst_num_col_m1,
    input  logic [2:0]               inst_elem_log2,
    input  logic                     inst_is_signed,
    output logic                     req_valid,
    input  logic                     req_ready,
    output logic [BW_ADDR-1:0]       req_addr,
    output logic [BW_ADDR-1:0]       req_size,
    output logic [BW_NUM_ROW_M1:0]   req_txn_info,
    input  logic                     rsp_fire,
    output logic [2:0]               cfg_elem_log2,
    output logic                     cfg_is_signed,
    output logic                     busy,
    output logic                     done,
    output logic                     err_underflow
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    // Row size in bits needs num_col_m1 width + 1 (the +1) + 5 (shift) + 1 (round-up carry).
    localparam int SZ_W  = BW_NUM_COL_M1 + 7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [BW_ADDR-1:0]       cur_addr_q, cur_addr_d;
    logic [BW_NUM_ROW_M1-1:0] row_idx_q, row_idx_d;
    logic [BW_NUM_ROW_M1-1:0] num_row_m1_q, num_row_m1_d;
    logic [BW_STRIDE_LS3-1:0] stride_q, stride_d;
    logic [BW_ADDR-1:0]       req_size_q, req_size_d;
    logic [2:0]               elem_q, elem_d;
    logic                     signed_q, signed_d;
    logic [CNT_W-1:0]         out_cnt_q, out_cnt_d;
    logic                     err_q, err_d;

    logic                     req_hs;
    logic                     is_last;
    logic [2:0]               elem_clamped;
    logic [SZ_W-1:0]          row_bits;
    logic [SZ_W-1:0]          row_bytes;

    assign elem_clamped = (inst_elem_log2 > 3'd5) ? 3'd5 : inst_elem_log2;
    assign row_bits     = (SZ_W'(inst_num_col_m1) + SZ_W'(1)) << elem_clamped;
    assign row_bytes    = (row_bits + SZ_W'(7)) >> 3;

    assign is_last = (row_idx_q == num_row_m1_q);
    // Throttle uses the registered count only, so a response in a full cycle
    // re-opens the request path one cycle later.
    assign req_valid = (state_q == S_ISSUE) && (out_cnt_q < CNT_W'(MAX_OUTSTANDING));
    assign req_hs    = req_valid & req_ready;

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        row_idx_d    = row_idx_q;
        num_row_m1_d = num_row_m1_q;
        stride_d     = stride_q;
        req_size_d   = req_size_q;
        elem_d       = elem_q;
        signed_d     = signed_q;
        out_cnt_d    = out_cnt_q;
        err_d        = err_q;
        done         = 1'b0;

        if (req_hs && !rsp_fire) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end else if (!req_hs && rsp_fire) begin
            if (out_cnt_q == '0) begin
                err_d = 1'b1;
            end else begin
                out_cnt_d = out_cnt_q - CNT_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (inst_valid) begin
                    state_d      = S_ISSUE;
                    cur_addr_d   = inst_addr;
                    row_idx_d    = '0;
                    num_row_m1_d = inst_num_row_m1;
                    stride_d     = inst_stride_ls3;
                    req_size_d   = BW_ADDR'(row_bytes);
                    elem_d       = elem_clamped;
                    signed_d     = inst_is_signed;
                    // A new instruction starts with a clean error flag.
                    err_d        = 1'b0;
                end
            end
            S_ISSUE: begin
                if (req_hs) begin
                    row_idx_d  = row_idx_q + BW_NUM_ROW_M1'(1);
                    cur_addr_d = cur_addr_q + BW_ADDR'({stride_q, 3'b000});
                    if (is_last) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (out_cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q      <= S_IDLE;
            cur_addr_q   <= '0;
            row_idx_q    <= '0;
            num_row_m1_q <= '0;
            stride_q     <= '0;
            req_size_q   <= '0;
            elem_q       <= '0;
            signed_q     <= 1'b0;
            out_cnt_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            row_idx_q    <= row_idx_d;
            num_row_m1_q <= num_row_m1_d;
            stride_q     <= stride_d;
            req_size_q   <= req_size_d;
            elem_q       <= elem_d;
            signed_q     <= signed_d;
            out_cnt_q    <= out_cnt_d;
            err_q        <= err_d;
        end
    end

    assign inst_ready    = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign req_addr      = cur_addr_q;
    assign req_size      = req_size_q;
    // Tag is zero outside ISSUE so an idle block shows no stale last_row flag.
    assign req_txn_info  = (state_q == S_ISSUE) ? {is_last, row_idx_q} : '0;
    assign cfg_elem_log2 = elem_q;
    assign cfg_is_signed = signed_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_dca_matrix_load_sequencer.sv
module tb_dca_matrix_load_sequencer;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rstnn;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_addr;
    logic [15:0] inst_stride_ls3;
    logic [7:0]  inst_num_row_m1;
    logic [7:0]  inst_num_col_m1;
    logic [2:0]  inst_elem_log2;
    logic        inst_is_signed;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_size;
    logic [8:0]  req_txn_info;
    logic        rsp_fire;
    logic [2:0]  cfg_elem_log2;
    logic        cfg_is_signed;
    logic        busy;
    logic        done;
    logic        err_underflow;

    always #5 clk = ~clk;

    dca_matrix_load_sequencer #(
        .BW_ADDR(32), .BW_STRIDE_LS3(16), .BW_NUM_ROW_M1(8),
        .BW_NUM_COL_M1(8), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rstnn(rstnn),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_addr(inst_addr), .inst_stride_ls3(inst_stride_ls3),
        .inst_num_row_m1(inst_num_row_m1), .inst_num_col_m1(inst_num_col_m1),
        .inst_elem_log2(inst_elem_log2), .inst_is_signed(inst_is_signed),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_size(req_size), .req_txn_info(req_txn_info),
        .rsp_fire(rsp_fire),
        .cfg_elem_log2(cfg_elem_log2), .cfg_is_signed(cfg_is_signed),
        .busy(busy), .done(done), .err_underflow(err_underflow)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: the instruction is expanded up front into the list of
    // rows it must produce; the rest is bookkeeping of counts.
    typedef struct {
        logic [31:0] addr;
        logic [8:0]  info;
    } req_t;

    req_t        exp_q[$];
    bit          m_active;
    int          m_outst;
    bit          m_err;
    logic [2:0]  m_elem;
    bit          m_sgn;
    logic [31:0] m_size;

    int          cyc;
    int          due_q[$];
    logic [31:0] hs_addr[$];
    logic [8:0]  hs_info[$];
    int          done_cnt;

    int          rsp_mode;   // 0 none, 1 random, 2 three cycles after each request
    bit          rdy_rand;
    bit          force_rsp;
    bit          inst_pend;

    task automatic model_reset();
        exp_q.delete();
        due_q.delete();
        m_active = 0;
        m_outst  = 0;
        m_err    = 0;
        m_elem   = '0;
        m_sgn    = 0;
        m_size   = '0;
    endtask

    task automatic model_accept();
        int e;
        int rows;
        req_t r;
        e    = (inst_elem_log2 > 3'd5) ? 5 : int'(inst_elem_log2);
        rows = int'(inst_num_row_m1) + 1;
        exp_q.delete();
        for (int i = 0; i < rows; i++) begin
            r.addr = inst_addr + 32'(i) * (32'(inst_stride_ls3) * 32'd8);
            r.info = {(i == rows - 1), 8'(i)};
            exp_q.push_back(r);
        end
        m_size   = 32'((((int'(inst_num_col_m1) + 1) << e) + 7) / 8);
        m_elem   = 3'(e);
        m_sgn    = inst_is_signed;
        m_err    = 0;
        m_active = 1;
    endtask

    task automatic cycle();
        bit exp_rv;
        bit exp_done;
        bit hs;
        @(negedge clk);
        inst_valid = inst_pend;
        req_ready  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        rsp_fire   = 1'b0;
        if (force_rsp) begin
            rsp_fire = 1'b1;
        end else if (rsp_mode == 1 && m_outst > 0) begin
            rsp_fire = ($urandom_range(0, 2) == 0);
        end else if (rsp_mode == 2 && due_q.size() > 0 && due_q[0] <= cyc) begin
            rsp_fire = 1'b1;
            void'(due_q.pop_front());
        end
        #1;
        exp_rv   = m_active && exp_q.size() > 0 && m_outst < MAXO;
        exp_done = m_active && exp_q.size() == 0 && m_outst == 0;
        chk("inst_ready", inst_ready, !m_active);
        chk("busy", busy, m_active);
        chk("req_valid", req_valid, exp_rv);
        chk("done", done, exp_done);
        chk("err_underflow", err_underflow, m_err);
        chk("cfg_elem_log2", cfg_elem_log2, m_elem);
        chk("cfg_is_signed", cfg_is_signed, m_sgn);
        if (exp_rv) begin
            chk("req_addr", req_addr, exp_q[0].addr);
            chk("req_txn_info", req_txn_info, exp_q[0].info);
        end
        if (m_active) chk("req_size", req_size, m_size);

        hs = exp_rv && req_ready;
        if (hs) begin
            hs_addr.push_back(exp_q[0].addr);
            hs_info.push_back(exp_q[0].info);
            void'(exp_q.pop_front());
            if (rsp_mode == 2) due_q.push_back(cyc + 3);
        end
        if (hs && !rsp_fire) m_outst++;
        else if (!hs && rsp_fire) begin
            if (m_outst > 0) m_outst--;
            else m_err = 1;
        end
        if (exp_done) begin
            m_active = 0;
            done_cnt++;
        end else if (!m_active && inst_valid) begin
            model_accept();
            inst_pend = 0;
        end
        cyc++;
    endtask

    task automatic launch(input logic [31:0] a, input logic [15:0] s, input logic [7:0] nr,
                          input logic [7:0] nc, input logic [2:0] e, input logic sg);
        inst_addr       = a;
        inst_stride_ls3 = s;
        inst_num_row_m1 = nr;
        inst_num_col_m1 = nc;
        inst_elem_log2  = e;
        inst_is_signed  = sg;
        inst_pend       = 1;
        hs_addr.delete();
        hs_info.delete();
        done_cnt = 0;
    endtask

    task automatic finish_inst(input int budget);
        for (int k = 0; k < budget; k++) begin
            cycle();
            if (!inst_pend && !m_active) break;
        end
        chk("inst_timeout", {inst_pend, m_active}, 2'b00);
    endtask

    initial begin
        rstnn = 1'b0;
        inst_valid = 0; inst_addr = '0; inst_stride_ls3 = '0; inst_num_row_m1 = '0;
        inst_num_col_m1 = '0; inst_elem_log2 = '0; inst_is_signed = 0;
        req_ready = 0; rsp_fire = 0;
        rsp_mode = 0; rdy_rand = 0; force_rsp = 0; inst_pend = 0;
        cyc = 0; done_cnt = 0;
        model_reset();

        repeat (2) @(negedge clk);
        #1;
        chk("rst_inst_ready", inst_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_valid", req_valid, 1'b0);
        chk("rst_req_addr", req_addr, 32'h0);
        chk("rst_req_size", req_size, 32'h0);
        chk("rst_txn_info", req_txn_info, 9'h0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err_underflow, 1'b0);
        chk("rst_cfg", {cfg_elem_log2, cfg_is_signed}, 4'h0);
        @(negedge clk);
        rstnn = 1'b1;

        // 4x4 int8, responses three cycles after each request.
        rsp_mode = 2; rdy_rand = 0;
        launch(32'h1000, 16'd2, 8'd3, 8'd3, 3'd3, 1'b0);
        finish_inst(100);
        chk("t1_nreq", hs_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < hs_addr.size()) begin
                chk("t1_addr", hs_addr[i], 32'h1000 + 32'(i) * 32'h10);
                chk("t1_last", hs_info[i][8], i == 3);
            end
        end
        chk("t1_size", req_size, 32'd4);
        chk("t1_done_pulses", done_cnt, 1);

        // Outstanding limit: no responses, eight rows.
        rsp_mode = 0;
        launch(32'h2000, 16'd1, 8'd7, 8'd0, 3'd5, 1'b1);
        repeat (10) cycle();
        chk("t2_nreq_full", hs_addr.size(), 4);
        chk("t2_valid_full", req_valid, 1'b0);
        force_rsp = 1;
        cycle();
        force_rsp = 0;
        cycle();
        chk("t2_nreq_after_rsp", hs_addr.size(), 5);
        rsp_mode = 1;
        finish_inst(300);
        chk("t2_nreq_total", hs_addr.size(), 8);
        chk("t2_cfg", {cfg_elem_log2, cfg_is_signed}, {3'd5, 1'b1});

        // Address wrap with random stalls.
        rdy_rand = 1;
        launch(32'hFFFF_FFF8, 16'd1, 8'd2, 8'd7, 3'd7, 1'b0);
        finish_inst(300);
        chk("t3_nreq", hs_addr.size(), 3);
        if (hs_addr.size() == 3) begin
            chk("t3_addr0", hs_addr[0], 32'hFFFF_FFF8);
            chk("t3_addr1", hs_addr[1], 32'h0000_0000);
            chk("t3_addr2", hs_addr[2], 32'h0000_0008);
        end

        // Underflow while idle, cleared by the next accepted instruction
        // (single row, zero stride).
        rsp_mode = 0;
        force_rsp = 1;
        cycle();
        force_rsp = 0;
        cycle();
        chk("t4_err_set", err_underflow, 1'b1);
        rsp_mode = 1;
        launch(32'h0000_0040, 16'd0, 8'd0, 8'd0, 3'd0, 1'b1);
        finish_inst(100);
        chk("t4_err_clear", err_underflow, 1'b0);
        chk("t4_single_last", hs_info.size() == 1 ? hs_info[0] : 9'h0, 9'h100);
        chk("t4_size", req_size, 32'd1);

        // Randomized instructions.
        for (int n = 0; n < 25; n++) begin
            launch($urandom(), 16'($urandom_range(0, 3) == 0 ? 0 : $urandom()),
                   8'($urandom_range(0, 12)), 8'($urandom()), 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)));
            finish_inst(600);
        end

        // Asynchronous reset while row 2 is being presented.
        rdy_rand = 0; rsp_mode = 0;
        launch(32'h3000, 16'd4, 8'd7, 8'd1, 3'd2, 1'b0);
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (hs_addr.size() == 2) break;
        end
        chk("t6_rows_before_rst", hs_addr.size(), 2);
        @(negedge clk);
        rsp_fire = 0;
        rstnn = 1'b0;
        #1;
        chk("t6_busy", busy, 1'b0);
        chk("t6_req_valid", req_valid, 1'b0);
        chk("t6_inst_ready", inst_ready, 1'b1);
        model_reset();
        @(negedge clk);
        rstnn = 1'b1;
        rsp_mode = 1; rdy_rand = 1;
        launch(32'h5000, 16'd3, 8'd5, 8'd15, 3'd4, 1'b1);
        finish_inst(300);
        chk("t6_post_rst_nreq", hs_addr.size(), 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
